// File: rtl/apb_master_q.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_q
//  Purpose  : APB master with a command queue, one-hot PSEL decode across
//             NSLV completers, back-to-back transfers, ACCESS timeout and a
//             buffered valid/ready response stream.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_q #(
  parameter  int DW     = 32,
  parameter  int AW     = 16,
  parameter  int NSLV   = 4,
  parameter  int DEPTH  = 4,
  parameter  int TO_CYC = 256,
  localparam int SW     = DW / 8,
  localparam int CW     = 1 + SW + DW + AW,
  localparam int RW     = 2 + DW
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic [CW-1:0]   i_cmd,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [RW-1:0]   o_resp,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic [NSLV-1:0] o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [SW-1:0]   o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready,
  output logic            o_busy
);

  localparam int SLW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TCW  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

  state_t state;
  logic [TCW-1:0] to_cnt;

  // command queue storage and pointers
  logic [CW-1:0]   cmd_mem [DEPTH];
  logic [PW-1:0]   cmd_wr, cmd_rd;
  logic [CNTW-1:0] cmd_cnt;

  // response queue storage and pointers
  logic [RW-1:0]   resp_mem [DEPTH];
  logic [PW-1:0]   resp_wr, resp_rd;
  logic [CNTW-1:0] resp_cnt;

  logic            cmd_push, cmd_pop, resp_push, resp_pop;
  logic [RW-1:0]   resp_din;
  logic            issue, done, tmo, credit;
  logic [CNTW-1:0] resp_after;

  // head-of-queue fields
  logic [CW-1:0]   head;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_wdata;
  logic [SW-1:0]   head_strb;
  logic            head_write;
  logic [SLW-1:0]  head_idx;
  logic            head_err;
  logic [NSLV-1:0] psel_next;

  assign head       = cmd_mem[cmd_rd];
  assign head_addr  = head[AW-1:0];
  assign head_wdata = head[AW +: DW];
  assign head_strb  = head[AW+DW +: SW];
  assign head_write = head[CW-1];

  // Slave index comes from the top address bits; an out-of-range index is
  // only possible when NSLV is not a power of two.
  generate
    if (NSLV == 1) begin : g_one_slave
      assign head_idx = '0;
      assign head_err = 1'b0;
    end else if ((1 << SLW) > NSLV) begin : g_partial_decode
      assign head_idx = head_addr[AW-1 -: SLW];
      assign head_err = (head_idx >= SLW'(NSLV));
    end else begin : g_full_decode
      assign head_idx = head_addr[AW-1 -: SLW];
      assign head_err = 1'b0;
    end
  endgenerate

  assign psel_next    = NSLV'(1) << head_idx;
  assign o_ready      = (cmd_cnt != CNTW'(DEPTH));
  assign o_resp_valid = (resp_cnt != '0);
  assign o_resp       = resp_mem[resp_rd];
  assign o_busy       = (cmd_cnt != '0) || (state != S_IDLE);

  assign cmd_push = i_valid && o_ready;
  assign resp_pop = o_resp_valid && i_resp_ready;
  assign done     = (state == S_ACCESS) && i_pready;
  assign tmo      = (state == S_ACCESS) && !i_pready && (TO_CYC != 0) && (to_cnt == TO_LAST);

  // Credit: a new transfer needs a free response slot after this cycle's
  // completion push and consumer pop have been accounted for.
  assign resp_after = resp_cnt + CNTW'(done || tmo) - CNTW'(resp_pop);
  assign credit     = (resp_after < CNTW'(DEPTH));

  // Decide completions, head pops, decode-error responses and new issues
  always_comb begin
    cmd_pop   = 1'b0;
    resp_push = 1'b0;
    resp_din  = '0;
    issue     = 1'b0;
    if (done) begin
      resp_push = 1'b1;
      resp_din  = {1'b0, i_pslverr, (o_pwrite ? {DW{1'b0}} : i_prdata)};
    end else if (tmo) begin
      resp_push = 1'b1;
      resp_din  = {2'b11, {DW{1'b0}}};
    end
    if ((cmd_cnt != '0) && credit) begin
      if (state == S_IDLE) begin
        cmd_pop = 1'b1;
        if (head_err) begin
          resp_push = 1'b1;
          resp_din  = {2'b01, {DW{1'b0}}};
        end else begin
          issue = 1'b1;
        end
      end else if (done && !head_err) begin
        cmd_pop = 1'b1;
        issue   = 1'b1;
      end
    end
  end

  // APB state machine with registered bus outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      o_psel    <= '0;
      o_penable <= 1'b0;
      o_paddr   <= '0;
      o_pwrite  <= 1'b0;
      o_pwdata  <= '0;
      o_pstrb   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_SETUP: begin
          o_penable <= 1'b1;
          to_cnt    <= '0;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (done || tmo) begin
            o_psel    <= '0;
            o_penable <= 1'b0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // A new transfer (from IDLE or back-to-back) overrides the above
      if (issue) begin
        state     <= S_SETUP;
        o_psel    <= psel_next;
        o_penable <= 1'b0;
        o_paddr   <= head_addr;
        o_pwrite  <= head_write;
        o_pwdata  <= head_wdata;
        o_pstrb   <= head_write ? head_strb : {SW{1'b0}};
      end
    end
  end

  // Queue pointers and occupancy counters
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cmd_wr   <= '0;
      cmd_rd   <= '0;
      cmd_cnt  <= '0;
      resp_wr  <= '0;
      resp_rd  <= '0;
      resp_cnt <= '0;
    end else begin
      if (cmd_push)  cmd_wr  <= cmd_wr + PW'(1);
      if (cmd_pop)   cmd_rd  <= cmd_rd + PW'(1);
      if (resp_push) resp_wr <= resp_wr + PW'(1);
      if (resp_pop)  resp_rd <= resp_rd + PW'(1);
      cmd_cnt  <= cmd_cnt + CNTW'(cmd_push) - CNTW'(cmd_pop);
      resp_cnt <= resp_cnt + CNTW'(resp_push) - CNTW'(resp_pop);
    end
  end

  // Queue storage writes (contents need no reset; occupancy gates reads)
  always_ff @(posedge pclk) begin
    if (cmd_push)  cmd_mem[cmd_wr]   <= i_cmd;
    if (resp_push) resp_mem[resp_wr] <= resp_din;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_q
//  Purpose  : Directed self-checking bench for apb_master_q (NSLV=3,
//             DEPTH=4, TO_CYC=8) with a combinational completer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_q;

  localparam int DW     = 32;
  localparam int AW     = 16;
  localparam int NSLV   = 3;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 8;
  localparam int SW     = DW / 8;
  localparam int CW     = 1 + SW + DW + AW;
  localparam int RW     = 2 + DW;

  logic            pclk = 1'b0;
  logic            preset = 1'b1;
  logic [CW-1:0]   i_cmd;
  logic            i_valid;
  logic            o_ready;
  logic [RW-1:0]   o_resp;
  logic            o_resp_valid;
  logic            i_resp_ready;
  logic [AW-1:0]   o_paddr;
  logic            o_pwrite;
  logic [NSLV-1:0] o_psel;
  logic            o_penable;
  logic [DW-1:0]   o_pwdata;
  logic [SW-1:0]   o_pstrb;
  logic [DW-1:0]   i_prdata;
  logic            i_pslverr;
  logic            i_pready;
  logic            o_busy;

  logic pready_en;
  logic slverr_en;

  int passed = 0;
  int total  = 0;
  int psel_cyc, setup_cyc, pen_cyc;

  apb_master_q #(
    .DW(DW), .AW(AW), .NSLV(NSLV), .DEPTH(DEPTH), .TO_CYC(TO_CYC)
  ) dut (
    .pclk(pclk), .preset(preset),
    .i_cmd(i_cmd), .i_valid(i_valid), .o_ready(o_ready),
    .o_resp(o_resp), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_prdata(i_prdata), .i_pslverr(i_pslverr), .i_pready(i_pready),
    .o_busy(o_busy)
  );

  always #5 pclk = ~pclk;

  // Completer: read data echoes the address so ordering is visible
  assign i_prdata  = {16'hBEEF, o_paddr};
  assign i_pready  = pready_en;
  assign i_pslverr = slverr_en;

  function automatic logic [CW-1:0] mk(input logic w, input logic [SW-1:0] s,
                                       input logic [DW-1:0] d, input logic [AW-1:0] a);
    return {w, s, d, a};
  endfunction

  function automatic logic [AW-1:0] addr4(input int k);
    return AW'((k % 3) << 14) | AW'(k * 4 + 'h100);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    if (o_psel != '0) psel_cyc++;
    if (o_psel != '0 && !o_penable) setup_cyc++;
    if (o_penable) pen_cyc++;
  endtask

  task automatic push(input logic [CW-1:0] c);
    i_cmd   = c;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra [4];
    int accepted, got, guard;
    logic acc_now;

    i_cmd = '0; i_valid = 1'b0; i_resp_ready = 1'b0;
    pready_en = 1'b1; slverr_en = 1'b0;
    psel_cyc = 0; setup_cyc = 0; pen_cyc = 0;

    // ---- reset state
    repeat (2) tick();
    check("rst_ready",   o_ready, 1);
    check("rst_rvalid",  o_resp_valid, 0);
    check("rst_psel",    o_psel, 0);
    check("rst_penable", o_penable, 0);
    check("rst_paddr",   o_paddr, 0);
    check("rst_busy",    o_busy, 0);
    preset = 1'b0;
    tick();

    // ---- single write to 0x4010: idx = addr[15:14] = 1
    push(mk(1'b1, 4'hF, 32'hA5A5A5A5, 16'h4010));
    check("wr_queued_psel", o_psel, 0);
    check("wr_queued_busy", o_busy, 1);
    tick();
    check("wr_setup_psel",  o_psel, 3'b010);
    check("wr_setup_pen",   o_penable, 0);
    check("wr_paddr",       o_paddr, 16'h4010);
    check("wr_pwdata",      o_pwdata, 32'hA5A5A5A5);
    check("wr_pstrb",       o_pstrb, 4'hF);
    check("wr_pwrite",      o_pwrite, 1);
    tick();
    check("wr_access_psel", o_psel, 3'b010);
    check("wr_access_pen",  o_penable, 1);
    tick();
    check("wr_done_psel",   o_psel, 0);
    check("wr_rvalid",      o_resp_valid, 1);
    check("wr_resp",        o_resp, 34'h0);
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("wr_popped",      o_resp_valid, 0);
    check("wr_idle_busy",   o_busy, 0);

    // ---- four back-to-back reads
    ra[0] = 16'h0004; ra[1] = 16'h4008; ra[2] = 16'h800C; ra[3] = 16'h0010;
    psel_cyc = 0;
    i_valid = 1'b1;
    i_cmd = mk(1'b0, 4'hF, 32'h12345678, ra[0]); tick();
    i_cmd = mk(1'b0, 4'hF, 32'h12345678, ra[1]); tick();
    check("rd_psel0",   o_psel, 3'b001);
    check("rd_pstrb0",  o_pstrb, 0);
    check("rd_pwrite0", o_pwrite, 0);
    i_cmd = mk(1'b0, 4'hF, 32'h12345678, ra[2]); tick();
    check("rd_pen0",    o_penable, 1);
    i_cmd = mk(1'b0, 4'hF, 32'h12345678, ra[3]); tick();
    i_valid = 1'b0;
    check("rd_b2b_psel1", o_psel, 3'b010);
    check("rd_b2b_pen1",  o_penable, 0);
    repeat (5) tick();
    check("rd_last_psel", o_psel, 3'b001);
    check("rd_last_pen",  o_penable, 1);
    tick();
    check("rd_end_psel",  o_psel, 0);
    check("rd_psel_cycles", psel_cyc, 8);
    i_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("rd_resp", o_resp, {2'b00, 16'hBEEF, ra[k]});
      tick();
    end
    i_resp_ready = 1'b0;
    check("rd_drained", o_resp_valid, 0);

    // ---- response back-pressure: only DEPTH transfers issue
    setup_cyc = 0; accepted = 0; guard = 0;
    while (accepted < 8 && guard < 40) begin
      i_cmd   = mk(1'b0, 4'h0, 32'h0, addr4(accepted));
      i_valid = 1'b1;
      acc_now = o_ready;
      tick();
      if (acc_now) accepted++;
      guard++;
    end
    i_valid = 1'b0;
    check("bp_accepted", accepted, 8);
    repeat (6) tick();
    check("bp_issued",   setup_cyc, 4);
    check("bp_ready",    o_ready, 0);
    check("bp_psel",     o_psel, 0);
    check("bp_rvalid",   o_resp_valid, 1);
    check("bp_busy",     o_busy, 1);
    i_resp_ready = 1'b1; got = 0; guard = 0;
    while (got < 8 && guard < 80) begin
      if (o_resp_valid) begin
        check("bp_resp", o_resp, {2'b00, 16'hBEEF, addr4(got)});
        got++;
      end
      tick();
      guard++;
    end
    i_resp_ready = 1'b0;
    check("bp_got",      got, 8);
    check("bp_end_busy", o_busy, 0);

    // ---- timeout: completer never ready
    pen_cyc = 0; pready_en = 1'b0;
    push(mk(1'b0, 4'hF, 32'h0, 16'h8020));
    push(mk(1'b0, 4'hF, 32'h0, 16'h4030));
    repeat (9) tick();
    check("to_pen_cycles", pen_cyc, 8);
    check("to_psel",       o_psel, 0);
    check("to_pen",        o_penable, 0);
    check("to_rvalid",     o_resp_valid, 1);
    check("to_resp",       o_resp, 34'h3_0000_0000);
    pready_en = 1'b1;
    tick();
    check("to_next_psel",  o_psel, 3'b010);
    tick();
    tick();
    check("to_next_done",  o_psel, 0);
    i_resp_ready = 1'b1;
    tick();
    check("to_next_resp",  o_resp, {2'b00, 16'hBEEF, 16'h4030});
    tick();
    i_resp_ready = 1'b0;
    check("to_drained",    o_resp_valid, 0);

    // ---- decode error (idx 3 with NSLV=3), then a read with PSLVERR
    slverr_en = 1'b1;
    push(mk(1'b1, 4'hF, 32'hDEADBEEF, 16'hC000));
    push(mk(1'b0, 4'h0, 32'h0, 16'h0044));
    check("de_psel",     o_psel, 0);
    check("de_rvalid",   o_resp_valid, 1);
    check("de_resp",     o_resp, 34'h1_0000_0000);
    tick();
    check("de_next_psel", o_psel, 3'b001);
    tick();
    tick();
    i_resp_ready = 1'b1;
    tick();
    check("de_next_resp", o_resp, {2'b01, 16'hBEEF, 16'h0044});
    tick();
    i_resp_ready = 1'b0;
    slverr_en = 1'b0;
    check("de_drained",  o_resp_valid, 0);

    // ---- asynchronous reset during ACCESS with two commands queued
    pready_en = 1'b0;
    push(mk(1'b0, 4'h0, 32'h0, 16'h0008));
    push(mk(1'b0, 4'h0, 32'h0, 16'h000C));
    push(mk(1'b0, 4'h0, 32'h0, 16'h4000));
    check("ar_in_access", o_penable, 1);
    preset = 1'b1;
    #1;
    check("ar_psel_now",  o_psel, 0);
    check("ar_pen_now",   o_penable, 0);
    tick();
    preset = 1'b0;
    tick();
    check("ar_ready",     o_ready, 1);
    check("ar_rvalid",    o_resp_valid, 0);
    check("ar_busy",      o_busy, 0);
    check("ar_psel",      o_psel, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
